pd_window_sched: RTL and testbench

- Shares one overlapping serial pattern detector between two serial requesters (channel 0 and channel 1).
- A requester asks for a measurement window of N bits. The block grants the detector round-robin, feeds the granted channel's bits through the match core for exactly N bits, counts overlapping matches, and returns the count with a done pulse.
- Sits between the serial input sources and downstream status/statistics logic.

---
 rtl/pd_sched_pkg.sv | 20 ++
 rtl/pd_match_core.sv | 59 +++++
 rtl/pd_window_sched.sv | 142 ++++++++++++++
 tb/tb_pd_window_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pd_sched_pkg.sv
// Shared types and defaults for the two-channel windowed pattern-detector scheduler.
package pd_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } state_e;

  localparam logic Ch0 = 1'b0;
  localparam logic Ch1 = 1'b1;

  localparam int unsigned DefPatW = 5;
  localparam logic [DefPatW-1:0] DefPattern = 5'b10101;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return (ch == Ch1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pd_match_core.sv
// Overlapping serial pattern matcher: shift register, fill counter and saturating match count.
module pd_match_core
  import pd_sched_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter logic [PAT_W-1:0] PATTERN = DefPattern,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic             match_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  logic [PAT_W-1:0] shift_q, shift_d, shift_next;
  logic [FillW-1:0] fill_q, fill_d, fill_next;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    shift_next = {shift_q[PAT_W-2:0], din_i};
    fill_next  = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
    // Fill saturates at PAT_W, so equality is the same as >= here.
    match_o    = shift_en_i && (fill_next == FillFull) && (shift_next == PATTERN);

    shift_d = shift_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (clr_i) begin
      shift_d = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (shift_en_i) begin
      shift_d = shift_next;
      fill_d  = fill_next;
      if (match_o && (count_q != '1)) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pd_window_sched.sv
// Round-robin scheduler sharing one pattern-match core between two serial channels,
// counting matches over a requested window and reporting the count with a done pulse.
module pd_window_sched
  import pd_sched_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter logic [PAT_W-1:0] PATTERN = DefPattern,
  parameter int unsigned WIN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [WIN_W-1:0] len0_i,
  input  logic [WIN_W-1:0] len1_i,
  input  logic             din0_i,
  input  logic             din1_i,
  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic             pd_o,
  output logic             done_o,
  output logic             done_id_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  state_e           state_q, state_d;
  logic             ch_q, ch_d;
  logic             rr_q, rr_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] bitcnt_q, bitcnt_d, bit_next;
  logic             pd_q, pd_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             pick_ch, din_sel, core_clr, core_shift, core_match;
  logic [CNT_W-1:0] core_cnt;

  pd_match_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (core_clr),
    .shift_en_i(core_shift),
    .din_i     (din_sel),
    .match_o   (core_match),
    .count_o   (core_cnt)
  );

  assign pick_ch = req_i[rr_q] ? rr_q : ~rr_q;
  assign din_sel = (ch_q == Ch1) ? din1_i : din0_i;
  assign bit_next = bitcnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rr_d        = rr_q;
    len_d       = len_q;
    bitcnt_d    = bitcnt_q;
    pd_d        = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    core_clr    = 1'b0;
    core_shift  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          ch_d     = pick_ch;
          len_d    = (pick_ch == Ch1) ? len1_i : len0_i;
          bitcnt_d = '0;
          core_clr = 1'b1;
          state_d  = (len_d == '0) ? StReport : StRun;
        end
      end
      StRun: begin
        if (!req_i[ch_q]) begin
          state_d = StIdle;
          rr_d    = ~ch_q;
        end else begin
          core_shift = 1'b1;
          pd_d       = core_match;
          bitcnt_d   = bit_next;
          if (bit_next == len_q) begin
            state_d     = StReport;
            done_d      = 1'b1;
            done_id_d   = ch_q;
            match_cnt_d = (core_match && (core_cnt != '1)) ? core_cnt + 1'b1 : core_cnt;
          end
        end
      end
      StReport: begin
        // A zero-length window arrives here without done; issue it one cycle later.
        if (!done_q) begin
          done_d      = 1'b1;
          done_id_d   = ch_q;
          match_cnt_d = core_cnt;
        end else begin
          state_d = StIdle;
          rr_d    = ~ch_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ch_q        <= Ch0;
      rr_q        <= Ch0;
      len_q       <= '0;
      bitcnt_q    <= '0;
      pd_q        <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      bitcnt_q    <= bitcnt_d;
      pd_q        <= pd_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign grant_o     = busy_o ? ch_onehot(ch_q) : 2'b00;
  assign pd_o        = pd_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_pd_window_sched.sv
// Scoreboard bench for pd_window_sched: directed windows push expected grants and done
// reports into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_pd_window_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_i;
  logic [7:0] len0_i, len1_i;
  logic       din0_i, din1_i;
  logic [1:0] grant_o;
  logic       busy_o, pd_o, done_o, done_id_o;
  logic [1:0] match_cnt_o;

  typedef struct packed {
    logic       id;
    logic [1:0] cnt;
    logic [7:0] pds;
    logic       pd_last;
  } done_exp_t;

  done_exp_t  exp_done_q[$];
  logic [1:0] exp_grant_q[$];

  int total = 0;
  int bad = 0;

  pd_window_sched #(
    .CNT_W(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req_i),
    .len0_i     (len0_i),
    .len1_i     (len1_i),
    .din0_i     (din0_i),
    .din1_i     (din1_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .pd_o       (pd_o),
    .done_o     (done_o),
    .done_id_o  (done_id_o),
    .match_cnt_o(match_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: grant order and done reports come from the queues.
  logic [1:0] grant_prev;
  int         pd_cnt;
  always @(negedge clk) begin
    if (rst) begin
      grant_prev = 2'b00;
      pd_cnt = 0;
    end else begin
      if (pd_o) pd_cnt++;
      if (grant_o != 2'b00 && grant_prev == 2'b00) begin
        if (exp_grant_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got %0b expected none at %0t", grant_o, $time);
        end else begin
          check("grant_order", grant_o, exp_grant_q.pop_front());
        end
      end
      grant_prev = grant_o;
      if (done_o) begin
        if (exp_done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got id=%0d cnt=%0d expected none at %0t",
                   done_id_o, match_cnt_o, $time);
        end else begin
          done_exp_t e;
          e = exp_done_q.pop_front();
          check("done_id", done_id_o, e.id);
          check("match_cnt", match_cnt_o, e.cnt);
          check("pd_pulses", pd_cnt, e.pds);
          check("pd_with_done", pd_o, e.pd_last);
        end
        pd_cnt = 0;
      end
    end
  end

  task automatic run_window(input logic ch, input int len, input logic [31:0] bits,
                            input int nfeed);
    int t;
    if (ch) len1_i = 8'(len);
    else len0_i = 8'(len);
    req_i[ch] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant_o[ch] !== 1'b1 && t < 20);
    check("grant_seen", grant_o[ch], 1'b1);
    for (int i = 0; i < nfeed; i++) begin
      // The other channel carries the inverse stream, which must be ignored.
      if (ch) begin
        din1_i = bits[i];
        din0_i = ~bits[i];
      end else begin
        din0_i = bits[i];
        din1_i = ~bits[i];
      end
      @(negedge clk);
    end
    if (nfeed == len) begin
      t = 0;
      while (done_o !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("done_latency", t, 0);
      req_i[ch] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req_i = 2'b11;
    len0_i = 8'd3;
    len1_i = 8'd3;
    din0_i = 1'b0;
    din1_i = 1'b0;

    // Reset held with both requests pending, then round-robin 0,1,0.
    exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01);
    exp_done_q.push_back('{id: 1'b0, cnt: 2'd0, pds: 8'd0, pd_last: 1'b0});
    exp_done_q.push_back('{id: 1'b1, cnt: 2'd0, pds: 8'd0, pd_last: 1'b0});
    exp_done_q.push_back('{id: 1'b0, cnt: 2'd0, pds: 8'd0, pd_last: 1'b0});
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {grant_o, busy_o, pd_o, done_o, match_cnt_o}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", grant_o, 2'b01);
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (done_o !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("rr_done_latency", t, 3);
      if (j == 2) req_i = 2'b00;
      @(negedge clk);
      check("idle_gap", busy_o, 1'b0);
      if (j < 2) begin
        @(negedge clk);
        check("rr_next_grant", grant_o, (j == 0) ? 2'b10 : 2'b01);
      end
    end

    // Zero-length window on channel 1.
    exp_grant_q.push_back(2'b10);
    exp_done_q.push_back('{id: 1'b1, cnt: 2'd0, pds: 8'd0, pd_last: 1'b0});
    len1_i = 8'd0;
    req_i = 2'b10;
    @(negedge clk);
    check("zl_grant_c1", {grant_o, done_o}, {2'b10, 1'b0});
    @(negedge clk);
    check("zl_grant_c2", {grant_o, done_o}, {2'b10, 1'b1});
    req_i = 2'b00;
    @(negedge clk);
    check("zl_release", grant_o, 2'b00);

    // Overlapping matches: 1,0,1,0,1,0,1.
    exp_grant_q.push_back(2'b01);
    exp_done_q.push_back('{id: 1'b0, cnt: 2'd2, pds: 8'd2, pd_last: 1'b1});
    run_window(1'b0, 7, 32'h55, 7);
    check("overlap_cnt_held", match_cnt_o, 2'd2);

    // Abort after 1,0,1: no done, count kept.
    exp_grant_q.push_back(2'b01);
    run_window(1'b0, 10, 32'h5, 3);
    req_i[0] = 1'b0;
    @(negedge clk);
    check("abort_grant_drop", {grant_o, busy_o}, 3'b000);
    repeat (3) @(negedge clk);
    check("abort_cnt_kept", match_cnt_o, 2'd2);

    // 0,1 after the aborted 1,0,1 must not complete 10101.
    exp_grant_q.push_back(2'b01);
    exp_done_q.push_back('{id: 1'b0, cnt: 2'd0, pds: 8'd0, pd_last: 1'b0});
    run_window(1'b0, 2, 32'h2, 2);

    // Saturation: 20 alternating bits give 8 matches, count clamps at 3.
    exp_grant_q.push_back(2'b01);
    exp_done_q.push_back('{id: 1'b0, cnt: 2'd3, pds: 8'd8, pd_last: 1'b0});
    run_window(1'b0, 20, 32'h55555, 20);

    // Reset in the middle of a run.
    exp_grant_q.push_back(2'b01);
    run_window(1'b0, 10, 32'h0, 3);
    #2;
    rst = 1'b1;
    req_i = 2'b00;
    #1;
    check("midrun_reset", {grant_o, busy_o, pd_o, done_o, match_cnt_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("after_reset_idle", {grant_o, done_o}, 3'b000);

    check("grant_queue_empty", exp_grant_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
